exec_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the 8085-subset datapath.
- Fetches opcode and operand bytes from program memory over a req/ack handshake.
- Drives the PC increment/load, the one-hot register-file write enables, the write-source mux and the ALU control.
- Supported subset: NOP, MVI, MOV, ALU-to-A, JMP and HLT over registers A, B, C, D.

---
 rtl/exec_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_exec_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Fetch/decode/execute controller for the 8085-subset datapath (NOP, MVI, MOV, ALU, JMP, HLT).
// Build option: define ILLEGAL_TRAP_EN to trap unsupported opcodes into FAULT with illegal_op.
module exec_sequencer #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [15:0] branch_address,
  output logic [3:0]  reg_wr_en,
  output logic [1:0]  wr_src,
  output logic [1:0]  rd_sel,
  output logic [7:0]  imm_data,
  output logic [2:0]  alu_ctrl,
  output logic        halted,
  output logic        bus_err,
  output logic        illegal_op
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPR1, S_OPR2, S_WB, S_EXEC, S_HALT, S_FAULT
  } state_t;

  localparam int WCW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((MEM_WAIT_MAX > 0) ? (MEM_WAIT_MAX - 1) : 0);

  // Register field codes: 111 = A, 000 = B, 001 = C, 010 = D.
  function automatic logic reg_ok(input logic [2:0] code);
    return (code == 3'b111) || (code == 3'b000) || (code == 3'b001) || (code == 3'b010);
  endfunction

  function automatic logic [3:0] reg_onehot(input logic [2:0] code);
    case (code)
      3'b111:  return 4'b1000;
      3'b000:  return 4'b0100;
      3'b001:  return 4'b0010;
      3'b010:  return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] reg_rdsel(input logic [2:0] code);
    case (code)
      3'b000:  return 2'd0;
      3'b001:  return 2'd1;
      3'b010:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic alu_ok(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b010) || (op == 3'b100) || (op == 3'b101) || (op == 3'b110);
  endfunction

  state_t         state_r;
  state_t         next_state_s;
  logic [7:0]     ir_r;
  logic [7:0]     lo_r;
  logic [WCW-1:0] wait_cnt_r;
  logic           req_state_s;
  logic           wait_hit_s;
  logic           timeout_s;
  logic           is_nop_s, is_mvi_s, is_mov_s, is_alu_s, is_jmp_s, is_hlt_s;

  logic           mem_req_r, pc_load_r, halted_r, bus_err_r;
  logic [15:0]    branch_r;
  logic [7:0]     imm_r;
  logic [3:0]     wr_en_r, wr_en_s;
  logic [1:0]     wr_src_r, wr_src_s, rd_sel_r, rd_sel_s;
  logic [2:0]     alu_r, alu_s;
  logic           load_s;
`ifdef ILLEGAL_TRAP_EN
  logic           illegal_r;
  logic           illegal_s;
`endif

  assign is_nop_s = (ir_r == 8'h00);
  assign is_mvi_s = (ir_r[7:6] == 2'b00) && (ir_r[2:0] == 3'b110) && reg_ok(ir_r[5:3]);
  assign is_mov_s = (ir_r[7:6] == 2'b01) && reg_ok(ir_r[5:3]) && reg_ok(ir_r[2:0]);
  assign is_alu_s = (ir_r[7:6] == 2'b10) && alu_ok(ir_r[5:3]) && reg_ok(ir_r[2:0]);
  assign is_jmp_s = (ir_r == 8'hC3);
  assign is_hlt_s = (ir_r == 8'h76);

  assign req_state_s = (state_r == S_FETCH) || (state_r == S_OPR1) || (state_r == S_OPR2);

  // Timeout detect: this wait cycle is the last one allowed.
  always_comb begin
    if (MEM_WAIT_MAX != 0) begin
      wait_hit_s = (wait_cnt_r == WAIT_LAST);
    end else begin
      wait_hit_s = 1'b0;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    timeout_s    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_s    = 1'b0;
`endif
    case (state_r)
      S_IDLE: next_state_s = S_FETCH;
      S_FETCH, S_OPR1, S_OPR2: begin
        if (mem_ack) begin
          case (state_r)
            S_FETCH: next_state_s = S_DECODE;
            S_OPR1:  next_state_s = is_jmp_s ? S_OPR2 : S_WB;
            S_OPR2:  next_state_s = S_EXEC;
            default: next_state_s = S_FAULT;
          endcase
        end else if (wait_hit_s) begin
          next_state_s = S_FAULT;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      S_DECODE: begin
        if (is_nop_s) begin
          next_state_s = S_FETCH;
        end else if (is_mvi_s || is_jmp_s) begin
          next_state_s = S_OPR1;
        end else if (is_mov_s || is_alu_s) begin
          next_state_s = S_EXEC;
        end else if (is_hlt_s) begin
          next_state_s = S_HALT;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          next_state_s = S_FAULT;
          illegal_s    = 1'b1;
`else
          next_state_s = S_FETCH;
`endif
        end
      end
      S_WB, S_EXEC: next_state_s = S_FETCH;
      S_HALT:       next_state_s = S_HALT;
      S_FAULT:      next_state_s = S_FAULT;
      default:      next_state_s = S_FAULT;
    endcase
  end

  // Datapath controls for the state being entered, so they can be registered.
  always_comb begin
    wr_en_s  = 4'b0000;
    wr_src_s = 2'd0;
    rd_sel_s = 2'd0;
    alu_s    = 3'd0;
    load_s   = 1'b0;
    if (next_state_s == S_WB) begin
      wr_en_s = reg_onehot(ir_r[5:3]);
    end else if (next_state_s == S_EXEC) begin
      if (is_jmp_s) begin
        load_s = 1'b1;
      end else if (is_mov_s) begin
        wr_src_s = 2'd1;
        rd_sel_s = reg_rdsel(ir_r[2:0]);
        wr_en_s  = reg_onehot(ir_r[5:3]);
      end else if (is_alu_s) begin
        wr_src_s = 2'd2;
        rd_sel_s = reg_rdsel(ir_r[2:0]);
        alu_s    = ir_r[5:3];
        wr_en_s  = 4'b1000;
      end else begin
        load_s = 1'b0;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // State, instruction/operand capture and wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      ir_r       <= 8'h00;
      lo_r       <= 8'h00;
      wait_cnt_r <= '0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == S_FETCH) && mem_ack) ir_r <= mem_rdata;
      if ((state_r == S_OPR1) && mem_ack)  lo_r <= mem_rdata;
      if (req_state_s && !mem_ack) begin
        wait_cnt_r <= wait_cnt_r + WCW'(1);
      end else begin
        wait_cnt_r <= '0;
      end
    end
  end

  // Registered outputs; branch and immediate hold until next reloaded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_r <= 1'b0;
      pc_load_r <= 1'b0;
      halted_r  <= 1'b0;
      bus_err_r <= 1'b0;
      branch_r  <= 16'h0000;
      imm_r     <= 8'h00;
      wr_en_r   <= 4'b0000;
      wr_src_r  <= 2'd0;
      rd_sel_r  <= 2'd0;
      alu_r     <= 3'd0;
`ifdef ILLEGAL_TRAP_EN
      illegal_r <= 1'b0;
`endif
    end else begin
      mem_req_r <= (next_state_s == S_FETCH) || (next_state_s == S_OPR1) || (next_state_s == S_OPR2);
      pc_load_r <= load_s;
      halted_r  <= halted_r || (next_state_s == S_HALT) || (next_state_s == S_FAULT);
      bus_err_r <= bus_err_r || timeout_s;
      wr_en_r   <= wr_en_s;
      wr_src_r  <= wr_src_s;
      rd_sel_r  <= rd_sel_s;
      alu_r     <= alu_s;
      if ((state_r == S_OPR1) && mem_ack && is_mvi_s) imm_r <= mem_rdata;
      if ((state_r == S_OPR2) && mem_ack) branch_r <= {mem_rdata, lo_r};
`ifdef ILLEGAL_TRAP_EN
      illegal_r <= illegal_r || illegal_s;
`endif
    end
  end

  assign mem_req        = mem_req_r;
  assign pc_inc         = mem_req_r & mem_ack;
  assign pc_load        = pc_load_r;
  assign branch_address = branch_r;
  assign reg_wr_en      = wr_en_r;
  assign wr_src         = wr_src_r;
  assign rd_sel         = rd_sel_r;
  assign imm_data       = imm_r;
  assign alu_ctrl       = alu_r;
  assign halted         = halted_r;
  assign bus_err        = bus_err_r;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_op     = illegal_r;
`else
  assign illegal_op     = 1'b0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a small program-memory responder and configurable ack waits.
module tb_exec_sequencer;

  logic        clk;
  logic        reset_n;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        pc_inc;
  logic        pc_load;
  logic [15:0] branch_address;
  logic [3:0]  reg_wr_en;
  logic [1:0]  wr_src;
  logic [1:0]  rd_sel;
  logic [7:0]  imm_data;
  logic [2:0]  alu_ctrl;
  logic        halted;
  logic        bus_err;
  logic        illegal_op;

  int          checks_cnt = 0;
  int          fail_cnt   = 0;
  logic [7:0]  prog [0:15];
  int          addr;
  int          wcnt;
  int          wait_cfg;
  int          inc_cnt;
  logic        ack_en;

  exec_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .pc_inc(pc_inc), .pc_load(pc_load),
    .branch_address(branch_address), .reg_wr_en(reg_wr_en), .wr_src(wr_src),
    .rd_sel(rd_sel), .imm_data(imm_data), .alu_ctrl(alu_ctrl), .halted(halted),
    .bus_err(bus_err), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_prog(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                           input logic [7:0] b6);
    for (int i = 0; i < 16; i++) prog[i] = 8'h76;
    prog[0] = b0; prog[1] = b1; prog[2] = b2; prog[3] = b3;
    prog[4] = b4; prog[5] = b5; prog[6] = b6;
  endtask

  // One clock: advance the memory model, then let outputs settle for sampling.
  task automatic tick();
    logic took;
    took = pc_inc;
    @(posedge clk);
    #1;
    if (took) begin
      addr = addr + 1;
      wcnt = 0;
    end
    if (mem_req && ack_en) begin
      if (wcnt < wait_cfg) begin
        mem_ack = 1'b0;
        wcnt++;
      end else begin
        mem_ack   = 1'b1;
        mem_rdata = prog[addr % 16];
      end
    end else begin
      mem_ack = 1'b0;
    end
    #1;
    if (pc_inc) inc_cnt++;
  endtask

  task automatic do_reset(input string tag);
    #2;
    reset_n = 1'b0;
    mem_ack = 1'b0;
    addr    = 0;
    wcnt    = 0;
    inc_cnt = 0;
    #1;
    check_eq({tag, "_async_clr"},
             64'({mem_req, pc_inc, pc_load, branch_address, reg_wr_en, wr_src, rd_sel,
                  imm_data, alu_ctrl, halted, bus_err, illegal_op}), 64'h0);
    repeat (2) @(posedge clk);
    #4;
    reset_n = 1'b1;
    #1;
    check_eq({tag, "_idle_req"}, 64'(mem_req), 64'h0);
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    ack_en    = 1'b1;
    wait_cfg  = 0;
    addr      = 0;
    wcnt      = 0;
    inc_cnt   = 0;

    // MVI A,5A ; MOV B,C ; ADD D ; ORA A ; 0xFF ; HLT, zero-wait memory
    fill_prog(8'h3E, 8'h5A, 8'h41, 8'h82, 8'hB7, 8'hFF, 8'h76);
    do_reset("p1");
    tick();
    check_eq("mvi_fetch_req", 64'(mem_req), 64'h1);
    check_eq("mvi_fetch_inc", 64'(pc_inc), 64'h1);
    tick();
    check_eq("mvi_dec_req", 64'(mem_req), 64'h0);
    tick();
    check_eq("mvi_opr_inc", 64'(pc_inc), 64'h1);
    tick();
    check_eq("mvi_wb", 64'({reg_wr_en, wr_src, imm_data, mem_req}), 64'({4'b1000, 2'd0, 8'h5A, 1'b0}));
    tick();
    check_eq("mvi_next_fetch", 64'({mem_req, reg_wr_en}), 64'({1'b1, 4'b0000}));
    repeat (2) tick();
    check_eq("mov_exec", 64'({reg_wr_en, wr_src, rd_sel}), 64'({4'b0100, 2'd1, 2'd1}));
    repeat (3) tick();
    check_eq("add_exec", 64'({reg_wr_en, wr_src, rd_sel, alu_ctrl}), 64'({4'b1000, 2'd2, 2'd2, 3'd0}));
    check_eq("imm_hold", 64'(imm_data), 64'h5A);
    repeat (3) tick();
    check_eq("ora_exec", 64'({reg_wr_en, wr_src, rd_sel, alu_ctrl}), 64'({4'b1000, 2'd2, 2'd3, 3'd6}));
    tick();
    check_eq("ff_fetch_inc", 64'(pc_inc), 64'h1);
    tick();
    check_eq("ff_dec_nowr", 64'(reg_wr_en), 64'h0);
    tick();
`ifdef ILLEGAL_TRAP_EN
    check_eq("ff_trap", 64'({illegal_op, halted, mem_req, bus_err}), 64'({1'b1, 1'b1, 1'b0, 1'b0}));
    tick();
    check_eq("ff_trap_sticky", 64'({illegal_op, halted, mem_req}), 64'({1'b1, 1'b1, 1'b0}));
`else
    check_eq("ff_as_nop", 64'({mem_req, illegal_op, reg_wr_en}), 64'({1'b1, 1'b0, 4'b0000}));
    tick();
    check_eq("hlt_dec", 64'(halted), 64'h0);
    tick();
    check_eq("hlt_halted", 64'({halted, mem_req, bus_err, illegal_op}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
    tick();
    check_eq("hlt_stays", 64'({halted, mem_req}), 64'({1'b1, 1'b0}));
`endif

    // JMP 0x1234 with two wait cycles per read
    fill_prog(8'hC3, 8'h34, 8'h12, 8'h76, 8'h76, 8'h76, 8'h76);
    wait_cfg = 2;
    do_reset("jmp");
    repeat (10) tick();
    check_eq("jmp_pre_load", 64'(pc_load), 64'h0);
    tick();
    check_eq("jmp_exec", 64'({pc_load, branch_address, reg_wr_en}), 64'({1'b1, 16'h1234, 4'b0000}));
    check_eq("jmp_inc_count", 64'(inc_cnt), 64'd3);
    tick();
    check_eq("jmp_after", 64'({pc_load, branch_address, mem_req}), 64'({1'b0, 16'h1234, 1'b1}));
    wait_cfg = 0;

    // HLT alone, then reset gives IDLE then FETCH
    fill_prog(8'h76, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    do_reset("hlt");
    repeat (2) tick();
    check_eq("hlt_not_yet", 64'(halted), 64'h0);
    tick();
    check_eq("hlt2_halted", 64'({halted, mem_req}), 64'({1'b1, 1'b0}));
    do_reset("hlt_rst");
    check_eq("hlt_rst_clear", 64'(halted), 64'h0);
    tick();
    check_eq("hlt_rst_fetch", 64'(mem_req), 64'h1);

    // Memory never acks: fault after the 15th wait cycle
    ack_en = 1'b0;
    do_reset("tmo");
    repeat (15) tick();
    check_eq("tmo_not_yet", 64'({bus_err, halted, mem_req}), 64'({1'b0, 1'b0, 1'b1}));
    tick();
    check_eq("tmo_fault", 64'({bus_err, halted, mem_req, illegal_op}), 64'({1'b1, 1'b1, 1'b0, 1'b0}));
    ack_en = 1'b1;

    // MVI B,77 then JMP; reset during OPR2 clears everything at once
    fill_prog(8'h06, 8'h77, 8'hC3, 8'h34, 8'h12, 8'h76, 8'h76);
    do_reset("mid");
    repeat (4) tick();
    check_eq("mid_mvi_b", 64'({reg_wr_en, imm_data}), 64'({4'b0100, 8'h77}));
    repeat (4) tick();
    check_eq("mid_opr2", 64'({mem_req, pc_inc}), 64'({1'b1, 1'b1}));
    do_reset("mid_rst");
    tick();
    check_eq("mid_refetch", 64'({mem_req, imm_data}), 64'({1'b1, 8'h00}));

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
